// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX opcodes, controller state encoding and opcode-class helper
package dlx_pkg;
  typedef enum logic [2:0] {IDLE, READ, OPER, RESW, WB} state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_FTYPE = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_RFE   = 6'h10;
  localparam logic [5:0] OP_TRAP  = 6'h11;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SGEI  = 6'h1D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LHU   = 6'h25;
  function automatic logic is_rtype(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_FTYPE;
  endfunction
endpackage

// File: rtl/dlx_dest_decode.sv
// dlx_dest_decode: instruction word -> write-back destination, write-required flag, extended immediate
//   instr in 32 | dest out REG_AW | wr out 1 | imm out DATA_W (imm16 or off26, sign-extended; 0 for R-type)
module dlx_dest_decode
  import dlx_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] dest,
  output logic              wr,
  output logic [DATA_W-1:0] imm
);
  logic [5:0] op;
  logic rtype, link, jtype;
  assign op    = instr[31:26];
  assign rtype = is_rtype(op);
  assign link  = op == OP_JAL || op == OP_JALR;
  assign jtype = op == OP_J || op == OP_JAL || op == OP_RFE || op == OP_TRAP;
  assign dest  = rtype ? REG_AW'(instr[15:11]) : link ? REG_AW'(LINK_REG) : REG_AW'(instr[20:16]);
  assign wr    = rtype || link || (op inside {[OP_ADDI:OP_LHI], [OP_SEQI:OP_SGEI], [OP_LB:OP_LHU]});
  assign imm   = rtype ? '0 :
                 jtype ? {{(DATA_W-26){instr[25]}}, instr[25:0]} :
                         {{(DATA_W-16){instr[15]}}, instr[15:0]};
endmodule

// File: rtl/dlx_regfile_access_ctrl.sv
// dlx_regfile_access_ctrl: one-instruction-in-flight RF read / execute handoff / write-back controller
//   instr_valid/instr_ready/instr : instruction intake (accepted only in IDLE)
//   rf_rs/rf_rt/rf_a/rf_b         : RF read ports, indices always from the held instruction
//   rf_rd/rf_we/rf_wdata          : RF write port, rf_we only in the WB cycle
//   op_valid/op_ready/op_*        : operands to execute;  res_valid/res_ready/res_data : result back
module dlx_regfile_access_ctrl
  import dlx_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_rs,
  output logic [REG_AW-1:0] rf_rt,
  output logic [REG_AW-1:0] rf_rd,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_imm,
  output logic [5:0]        op_opcode,
  output logic [10:0]       op_func,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy
);
  state_t state, state_n;
  logic [31:0] ir;
  logic [DATA_W-1:0] a, b, r;
  logic [REG_AW-1:0] dest;
  logic wr, do_wb;
  dlx_dest_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LINK_REG(LINK_REG)) u_dec (
    .instr(ir),
    .dest (dest),
    .wr   (wr),
    .imm  (op_imm)
  );
  // R0 is hardwired zero, so a write to it skips the WB cycle entirely
  assign do_wb = wr && dest != '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      r     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == READ) begin
        a <= rf_a;
        b <= rf_b;
      end
      if (state == RESW && res_valid) r <= res_data;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = instr_valid ? READ : IDLE;
      READ:    state_n = OPER;
      OPER:    state_n = op_ready ? RESW : OPER;
      RESW:    state_n = !res_valid ? RESW : do_wb ? WB : IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign instr_ready = state == IDLE;
  assign op_valid    = state == OPER;
  assign res_ready   = state == RESW;
  assign rf_we       = state == WB;
  assign busy        = state != IDLE;
  assign rf_rs       = REG_AW'(ir[25:21]);
  assign rf_rt       = REG_AW'(ir[20:16]);
  assign rf_rd       = dest;
  assign rf_wdata    = r;
  assign op_a        = a;
  assign op_b        = b;
  assign op_opcode   = ir[31:26];
  assign op_func     = is_rtype(ir[31:26]) ? ir[10:0] : '0;
endmodule

// File: tb/tb_dlx_regfile_access_ctrl.sv
// tb_dlx_regfile_access_ctrl: directed vector table plus stall and reset sequences for the RF access controller
module tb_dlx_regfile_access_ctrl;
  logic        clock = 0;
  logic        reset = 1;
  logic        instr_valid = 0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rf_rs, rf_rt, rf_rd;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_a, rf_b;
  logic        op_valid;
  logic        op_ready = 1;
  logic [31:0] op_a, op_b, op_imm;
  logic [5:0]  op_opcode;
  logic [10:0] op_func;
  logic        res_valid = 1;
  logic        res_ready;
  logic [31:0] res_data = '0;
  logic        busy;
  int checks = 0;
  int fails = 0;
  dlx_regfile_access_ctrl dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_a(rf_a), .rf_b(rf_b), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_imm(op_imm), .op_opcode(op_opcode), .op_func(op_func), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );
  always #5 clock = ~clock;
  logic [31:0] regs [32];
  bit rf_init = 1;
  always @(posedge clock)
    if (rf_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[1] <= 32'd5;
      regs[2] <= 32'd7;
    end else if (rf_we && rf_rd != 0) regs[rf_rd] <= rf_wdata;
  assign rf_a = regs[rf_rs];
  assign rf_b = regs[rf_rt];
  typedef struct {
    logic [31:0] instr;
    logic [31:0] res;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [10:0] func;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } vec_t;
  vec_t tab [12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input string nm, input vec_t v);
    logic [31:0] ca, cb, cimm, cwd;
    logic [4:0]  crs, crt, crd;
    logic [10:0] cfunc;
    int op_cyc, we_cnt, we_cyc, idle_cyc;
    op_cyc = 0; we_cnt = 0; we_cyc = 0; idle_cyc = 0;
    ca = 'x; cb = 'x; cimm = 'x; cwd = 'x; crs = 'x; crt = 'x; crd = 'x; cfunc = 'x;
    @(negedge clock);
    res_data = v.res;
    instr = v.instr;
    instr_valid = 1;
    chk({nm, " instr_ready"}, 32'(instr_ready), 1);
    @(posedge clock);
    #1 instr_valid = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (op_valid) begin
        op_cyc = c; ca = op_a; cb = op_b; cimm = op_imm; cfunc = op_func; crs = rf_rs; crt = rf_rt;
      end
      if (rf_we) begin
        we_cnt++; we_cyc = c; crd = rf_rd; cwd = rf_wdata;
      end
      if (instr_ready) begin
        idle_cyc = c;
        break;
      end
    end
    chk({nm, " op_cycle"}, op_cyc, 2);
    chk({nm, " rf_rs"}, crs, v.rs);
    chk({nm, " rf_rt"}, crt, v.rt);
    chk({nm, " op_a"}, ca, v.a);
    chk({nm, " op_b"}, cb, v.b);
    chk({nm, " op_imm"}, cimm, v.imm);
    chk({nm, " op_func"}, cfunc, v.func);
    chk({nm, " we_pulses"}, we_cnt, v.we);
    chk({nm, " idle_cycle"}, idle_cyc, v.we ? 5 : 4);
    if (v.we) begin
      chk({nm, " we_cycle"}, we_cyc, 4);
      chk({nm, " rf_rd"}, crd, v.rd);
      chk({nm, " rf_wdata"}, cwd, v.wdata);
    end
  endtask
  initial begin
    vec_t post;
    //            instr         res            rs  rt  a          b          imm            func     we rd  wdata
    tab[0]  = '{32'h00221820, 32'd12,        1,  2,  32'd5,     32'd7,     32'h0,         11'h020, 1, 3,  32'd12};
    tab[1]  = '{32'h2024FFFF, 32'd4,         1,  4,  32'd5,     32'd0,     32'hFFFFFFFF,  11'h0,   1, 4,  32'd4};
    tab[2]  = '{32'h2020FFFF, 32'd9,         1,  0,  32'd5,     32'd0,     32'hFFFFFFFF,  11'h0,   0, 0,  32'd0};
    tab[3]  = '{32'hAC220008, 32'h33,        1,  2,  32'd5,     32'd7,     32'h8,         11'h0,   0, 0,  32'd0};
    tab[4]  = '{32'h10200010, 32'h44,        1,  0,  32'd5,     32'd0,     32'h10,        11'h0,   0, 0,  32'd0};
    tab[5]  = '{32'h0C000100, 32'h104,       0,  0,  32'd0,     32'd0,     32'h100,       11'h0,   1, 31, 32'h104};
    tab[6]  = '{32'h0FFFFFFC, 32'h200,       31, 31, 32'h104,   32'h104,   32'hFFFFFFFC,  11'h0,   1, 31, 32'h200};
    tab[7]  = '{32'h3C051234, 32'h12340000,  0,  5,  32'd0,     32'd0,     32'h1234,      11'h0,   1, 5,  32'h12340000};
    tab[8]  = '{32'h8C66FFFC, 32'hDEAD,      3,  6,  32'd12,    32'd0,     32'hFFFFFFFC,  11'h0,   1, 6,  32'hDEAD};
    tab[9]  = '{32'h4BE00000, 32'h77,        31, 0,  32'h200,   32'd0,     32'h0,         11'h0,   0, 0,  32'd0};
    tab[10] = '{32'h4C600000, 32'h55,        3,  0,  32'd12,    32'd0,     32'h0,         11'h0,   1, 31, 32'h55};
    tab[11] = '{32'h00220020, 32'd12,        1,  2,  32'd5,     32'd7,     32'h0,         11'h020, 0, 0,  32'd0};
    repeat (2) @(negedge clock);
    chk("rst instr_ready", 32'(instr_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst op_valid", 32'(op_valid), 0);
    chk("rst res_ready", 32'(res_ready), 0);
    chk("rst rf_we", 32'(rf_we), 0);
    chk("rst rf_wdata", rf_wdata, 0);
    chk("rst op_a", op_a, 0);
    chk("rst op_imm", op_imm, 0);
    chk("rst rf_rd", 32'(rf_rd), 0);
    reset = 0;
    rf_init = 0;
    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tab[i]);
    // stall: ADD r7,r1,r2 with op_ready low 3 cycles then res_valid low 2 cycles
    op_ready = 0;
    res_valid = 0;
    @(negedge clock);
    instr = 32'h00223820;
    instr_valid = 1;
    @(posedge clock);
    #1 instr_valid = 0;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("stall op_valid%0d", k), 32'(op_valid), 1);
      chk($sformatf("stall op_a%0d", k), op_a, 5);
      chk($sformatf("stall op_b%0d", k), op_b, 7);
      chk($sformatf("stall op_func%0d", k), 32'(op_func), 32'h20);
      chk($sformatf("stall instr_ready%0d", k), 32'(instr_ready), 0);
    end
    op_ready = 1;
    @(posedge clock);
    #1 op_ready = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk($sformatf("stall res_ready%0d", k), 32'(res_ready), 1);
      chk($sformatf("stall op_valid_off%0d", k), 32'(op_valid), 0);
      chk($sformatf("stall rf_we%0d", k), 32'(rf_we), 0);
      chk($sformatf("stall instr_ready_r%0d", k), 32'(instr_ready), 0);
    end
    res_data = 32'd99;
    res_valid = 1;
    @(posedge clock);
    #1 res_valid = 0;
    @(negedge clock);
    chk("stall wb rf_we", 32'(rf_we), 1);
    chk("stall wb rf_rd", 32'(rf_rd), 7);
    chk("stall wb rf_wdata", rf_wdata, 99);
    chk("stall wb instr_ready", 32'(instr_ready), 0);
    @(negedge clock);
    chk("stall idle", 32'(instr_ready), 1);
    // reset while waiting in OPER
    @(negedge clock);
    instr = 32'h00221820;
    instr_valid = 1;
    @(posedge clock);
    #1 instr_valid = 0;
    repeat (2) @(negedge clock);
    chk("oper pre op_valid", 32'(op_valid), 1);
    reset = 1;
    #1;
    chk("oper rst op_valid", 32'(op_valid), 0);
    chk("oper rst busy", 32'(busy), 0);
    chk("oper rst instr_ready", 32'(instr_ready), 1);
    chk("oper rst op_a", op_a, 0);
    #1 reset = 0;
    op_ready = 1;
    res_valid = 1;
    @(negedge clock);
    chk("oper post busy", 32'(busy), 0);
    // reset during the WB cycle of ADD r8,r1,r2
    res_data = 32'd12;
    instr = 32'h00224020;
    instr_valid = 1;
    @(posedge clock);
    #1 instr_valid = 0;
    repeat (4) @(negedge clock);
    chk("wb pre rf_we", 32'(rf_we), 1);
    chk("wb pre rf_rd", 32'(rf_rd), 8);
    reset = 1;
    #1;
    chk("wb rst rf_we", 32'(rf_we), 0);
    chk("wb rst rf_wdata", rf_wdata, 0);
    chk("wb rst op_valid", 32'(op_valid), 0);
    chk("wb rst instr_ready", 32'(instr_ready), 1);
    #1 reset = 0;
    @(negedge clock);
    chk("wb abandoned r8", regs[8], 0);
    post = '{32'h00224820, 32'd12, 1, 2, 32'd5, 32'd7, 32'h0, 11'h020, 1, 9, 32'd12};
    run_vec("post_rst", post);
    @(negedge clock);
    chk("post_rst r9", regs[9], 12);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
